fifo_rd_arb: RTL and testbench
==============================

FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of consumers sharing one FIFO read port; legal range 2..8.
REQ-002 Parameter BURST_LEN, default 4: maximum words popped per grant; legal range 1..16.
REQ-003 Parameter STALL_MAX, default 8: consecutive empty cycles during a burst that force release; legal range 1..255.
REQ-004 r_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 r_rst  input  1  reset, synchronous, active-high.
REQ-006 req    input  NUM_REQ  per-consumer read request, level, held until served or abandoned.
REQ-007 r_empty  input  1  FIFO read-side empty flag.
REQ-008 r_pop  output  1  pop strobe to the FIFO read side.
REQ-009 gnt    output  NUM_REQ  one-hot grant, registered; all-zero when idle.
REQ-010 rd_vld output  NUM_REQ  one-hot data-valid; FIFO read data belongs to the flagged consumer this cycle.
REQ-011 busy   output  1  high while in BURST.

Function
REQ-012 FSM states are IDLE and BURST only.
REQ-013 IDLE: if any req bit is high, the next cycle enters BURST with gnt = the first requester at or after the round-robin pointer (wrapping modulo NUM_REQ).
REQ-014 IDLE with req all-zero stays in IDLE with gnt = 0.
REQ-015 BURST: r_pop = req[owner] AND NOT r_empty, combinational from registered state; never asserted in IDLE.
REQ-016 Per-burst word counter increments on each r_pop; width ceil(log2(BURST_LEN))+1.
REQ-017 BURST -> IDLE when r_pop fires with count = BURST_LEN-1 (burst complete).
REQ-018 BURST -> IDLE when req[owner] is low (abandon); no pop that cycle.
REQ-019 Stall counter increments each BURST cycle with r_empty high and req[owner] high; clears on any pop; BURST -> IDLE when it reaches STALL_MAX-1 while still empty.
REQ-020 On every BURST -> IDLE transition, the round-robin pointer becomes owner+1 modulo NUM_REQ, and gnt clears.
REQ-021 Word counter and stall counter clear on entry to BURST.
REQ-022 rd_vld = gnt-at-pop registered one cycle: rd_vld[i] is high exactly one cycle after each r_pop issued under owner i (FIFO RAM read latency 1), including the pop on the last burst cycle.
REQ-023 Back-to-back grants incur exactly one IDLE cycle between bursts.
REQ-024 A req change of a non-owner during BURST has no effect until the next IDLE arbitration.
REQ-025 gnt stays one-hot and unchanged for the whole BURST.
REQ-026 rd_vld is never asserted for two consumers in the same cycle.

Reset
REQ-027 While r_rst is high at a clock edge: FSM = IDLE, gnt = 0, rd_vld = 0, busy = 0, both counters = 0, round-robin pointer = 0.
REQ-028 r_pop is 0 during and after reset until a new grant.
REQ-029 Reset asserted mid-burst aborts the burst at that edge; no rd_vld for a pop issued in the reset cycle.

Structure
REQ-030 Shared package holds the FSM state encoding (IDLE, BURST) and helper constants for counter widths derived from BURST_LEN and STALL_MAX.
REQ-031 One sub-module: rr_pick, a combinational round-robin selector (req vector + pointer -> one-hot choice).
REQ-032 Block sits between the FIFO read side and consumers; it is the only driver of the FIFO pop input.

Verification
REQ-033 NUM_REQ=4, BURST_LEN=4; req=0001, FIFO holds 10 words -> gnt=0001 for 4 pop cycles, rd_vld[0] 4 pulses, then IDLE 1 cycle, re-grant 0001.
REQ-034 req=1111 steady, FIFO never empty -> grant order 0,1,2,3,0; each burst exactly 4 pops; one idle cycle between bursts.
REQ-035 req=0010, FIFO holds 2 words, STALL_MAX=8 -> 2 pops, then 8 empty cycles, release to IDLE; pointer = 2.
REQ-036 req[2] dropped after 2 pops of its burst -> no further pop, IDLE next cycle, pointer = 3, rd_vld[2] totals 2 pulses.
REQ-037 r_rst pulsed during 3rd pop of a burst -> gnt, rd_vld, busy = 0 next cycle; pointer = 0; subsequent req=1000 granted first.
REQ-038 Random req/empty soak -> r_pop never high while r_empty high; gnt always one-hot or zero; rd_vld count equals r_pop count per consumer.

Source files
------------

// File: rtl/fifo_rd_arb_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encoding and
// counter-width helper used to size the burst and stall counters.
package fifo_rd_arb_pkg;

    // FSM encoding; only two states exist
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Width of a counter that must hold values 0..n-1 with one spare bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_arb_rr_pick.sv
// Combinational round-robin selector: returns the first requester at or
// after the pointer, wrapping modulo NUM_REQ, as one-hot and as an index.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_onehot,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic w_found;

    // Pointer plus offset, wrapped into 0..NUM_REQ-1 (pointer is always < NUM_REQ)
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p,
                                                  input int unsigned      k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from the pointer and keep the first active request
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req[wrap_idx(i_ptr, k)]) begin
                w_found                     = 1'b1;
                o_idx                       = wrap_idx(i_ptr, k);
                o_onehot[wrap_idx(i_ptr, k)] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fifo_rd_arb.sv
// FIFO read-port arbiter: grants one consumer at a time a burst of up to
// BURST_LEN pops, releasing early on abandon or a prolonged empty stall.
// Read data returns one cycle after each pop, flagged by rd_vld.
module fifo_rd_arb
    import fifo_rd_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned STALL_MAX = 8
) (
    input  logic               r_clk,
    input  logic               r_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               r_empty,
    output logic               r_pop,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rd_vld,
    output logic               busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned WCNT_W = cnt_width(BURST_LEN);
    localparam int unsigned SCNT_W = cnt_width(STALL_MAX);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [SCNT_W-1:0]  r_scnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_vld;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any;
    logic               w_in_burst;
    logic               w_pop;
    logic               w_last_word;
    logic               w_stall_out;
    logic               w_release;
    logic [IDX_W-1:0]   w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    assign w_in_burst  = (r_state == ST_BURST);
    assign w_pop       = w_in_burst & req[r_owner] & ~r_empty;
    assign w_last_word = (r_wcnt == WCNT_W'(BURST_LEN - 1));
    assign w_stall_out = (r_scnt == SCNT_W'(STALL_MAX - 1));
    assign w_release   = w_in_burst &
                         ((w_pop & w_last_word) | ~req[r_owner] | (r_empty & w_stall_out));
    assign w_next_ptr  = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // Arbitration, burst/stall counting and one-cycle-delayed data-valid
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_wcnt  <= '0;
            r_scnt  <= '0;
            r_gnt   <= '0;
            r_vld   <= '0;
        end else begin
            r_vld <= w_pop ? r_gnt : '0;
            if (r_state == ST_IDLE) begin
                if (w_any) begin
                    r_state <= ST_BURST;
                    r_gnt   <= w_pick_oh;
                    r_owner <= w_pick_idx;
                    r_wcnt  <= '0;
                    r_scnt  <= '0;
                end
            end else if (w_release) begin
                r_state <= ST_IDLE;
                r_gnt   <= '0;
                r_ptr   <= w_next_ptr;
            end else if (w_pop) begin
                r_wcnt <= r_wcnt + WCNT_W'(1);
                r_scnt <= '0;
            end else begin
                r_scnt <= r_scnt + SCNT_W'(1);
            end
        end
    end

    assign r_pop  = w_pop;
    assign gnt    = r_gnt;
    assign rd_vld = r_vld;
    assign busy   = w_in_burst;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Self-checking bench for fifo_rd_arb: directed scenarios plus a random
// soak, all compared cycle by cycle against a burst-level reference model.
module tb_fifo_rd_arb;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int SM = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         empty;
    logic         pop;
    logic         busy;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] vld;

    always #5 clk = ~clk;

    fifo_rd_arb #(
        .NUM_REQ   (N),
        .BURST_LEN (BL),
        .STALL_MAX (SM)
    ) dut (
        .r_clk   (clk),
        .r_rst   (rst),
        .req     (req),
        .r_empty (empty),
        .r_pop   (pop),
        .gnt     (gnt),
        .rd_vld  (vld),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, how far the burst has progressed
    bit m_busy;
    int m_owner, m_words, m_stall, m_ptr, m_vld;
    int level;
    int pops [N];
    int vlds [N];
    logic [N-1:0] gq [$];
    logic [N-1:0] prev_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_release();
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
    endtask

    // One clock cycle: apply inputs, compare against model, advance model
    task automatic cycle(input logic [N-1:0] rq, input bit rs, input int push);
        bit           e_pop;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_vld;
        req   = rq;
        rst   = rs;
        empty = (level == 0);
        #1;
        e_gnt = '0;
        if (m_busy) e_gnt[m_owner] = 1'b1;
        e_pop = m_busy && rq[m_owner] && (level != 0);
        e_vld = '0;
        if (m_vld >= 0) e_vld[m_vld] = 1'b1;
        chk("gnt", gnt, e_gnt);
        chk("busy", busy, m_busy);
        chk("pop", pop, e_pop);
        chk("rd_vld", vld, e_vld);
        chk("pop_while_empty", pop & empty, 0);
        chk("gnt_onehot0", $onehot0(gnt), 1);
        chk("vld_onehot0", $onehot0(vld), 1);
        for (int i = 0; i < N; i++) begin
            if (pop && gnt[i] && !rs) pops[i]++;
            if (vld[i]) vlds[i]++;
        end
        if (gnt != 0 && prev_gnt == 0) gq.push_back(gnt);
        prev_gnt = gnt;
        if (rs) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_vld  = -1;
        end else begin
            m_vld = e_pop ? m_owner : -1;
            if (!m_busy) begin
                if (rq != 0) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                    m_busy  = 1'b1;
                    m_words = 0;
                    m_stall = 0;
                end
            end else if (e_pop) begin
                m_words++;
                m_stall = 0;
                if (m_words == BL) model_release();
            end else if (!rq[m_owner]) begin
                model_release();
            end else begin
                m_stall++;
                if (m_stall == SM) model_release();
            end
        end
        if (pop && level > 0) level--;
        level += push;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_ord [5];
    int           base;

    initial begin
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) begin
            pops[i] = 0;
            vlds[i] = 0;
        end
        level    = 0;
        prev_gnt = '0;
        rst      = 1'b1;
        req      = '0;
        empty    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_busy = 1'b0; m_ptr = 0; m_vld = -1; m_owner = 0; m_words = 0; m_stall = 0;

        // Reset state
        cycle('0, 1'b0, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", vld, 0);
        chk("rst_pop", pop, 0);

        // Single requester, 10 words: two full bursts with one idle cycle between
        level = 10;
        repeat (11) cycle(4'b0001, 1'b0, 0);
        cycle('0, 1'b0, 0);
        chk("s033_pops", pops[0], 8);
        chk("s033_vlds", vlds[0], 8);
        level = 0;

        // All requesting, FIFO never empty: rotation 0,1,2,3,0
        cycle('0, 1'b1, 0);
        gq.delete();
        level = 1000;
        repeat (25) cycle(4'b1111, 1'b0, 0);
        chk("s034_grants", gq.size(), 5);
        for (int k = 0; k < 5 && k < gq.size(); k++) chk("s034_order", gq[k], exp_ord[k]);

        // Two words then stall out after STALL_MAX empty cycles; pointer moves to 2
        cycle('0, 1'b1, 0);
        level = 2;
        repeat (11) cycle(4'b0010, 1'b0, 0);
        chk("s035_idle", busy, 0);
        level = 100;
        cycle(4'b1111, 1'b0, 0);
        chk("s035_ptr", gnt, 4'b0100);

        // Owner 2 abandons after two pops; pointer moves to 3
        cycle('0, 1'b1, 0);
        base = vlds[2];
        cycle(4'b0100, 1'b0, 0);
        cycle(4'b0100, 1'b0, 0);
        cycle(4'b0100, 1'b0, 0);
        cycle(4'b0000, 1'b0, 0);
        chk("s036_idle", busy, 0);
        cycle(4'b1111, 1'b0, 0);
        chk("s036_ptr", gnt, 4'b1000);
        chk("s036_vld2", vlds[2] - base, 2);

        // Reset during the third pop aborts the burst
        cycle('0, 1'b1, 0);
        cycle(4'b0001, 1'b0, 0);
        cycle(4'b0001, 1'b0, 0);
        cycle(4'b0001, 1'b0, 0);
        cycle(4'b0001, 1'b1, 0);
        chk("s037_gnt", gnt, 0);
        chk("s037_busy", busy, 0);
        chk("s037_vld", vld, 0);
        cycle(4'b1000, 1'b0, 0);
        chk("s037_first", gnt, 4'b1000);
        cycle(4'b1000, 1'b1, 0);

        // Random soak
        level = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 3 == 0) req = 4'($urandom_range(0, 15));
            cycle(req, ($urandom_range(0, 499) == 0), (level < 6) ? $urandom_range(0, 2) : 0);
        end
        cycle('0, 1'b0, 0);
        cycle('0, 1'b0, 0);
        for (int i = 0; i < N; i++) chk("soak_vld_vs_pop", vlds[i], pops[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
